// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard controller.
// Keeps a small counter per architectural register of issued instructions
// that still owe a write-back. It stalls decode on read-after-write hazards or
// when a destination counter is full. It also offers a drain handshake so the
// core can be emptied before interrupts, debug or stack swaps.
module hazard_scoreboard #(
  parameter int NREGS       = 32,
  parameter int CNT_W       = 2,
  parameter int STALL_LIMIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_reg_write_i,
  input  logic [4:0]       id_dest_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_dest_i,
  input  logic             flush_i,
  input  logic             drain_req_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic             bubble_o,
  output logic [NREGS-1:0] busy_map_o,
  output logic [5:0]       inflight_o,
  output logic             drain_done_o,
  output logic             err_underflow_o,
  output logic             stall_timeout_o
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [5:0]       inflight_q, inflight_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;
  logic             tout_q, tout_d;
  logic             raw, sat;
  logic             inc, dec, same, dec_ok;
  logic             next_empty;

  // Hazard terms; register 0 is hard-wired and never creates a dependency.
  always_comb begin
    raw = id_valid_i &
          ((id_use_rs_i & (id_rs_i != 5'd0) & (cnt_q[id_rs_i] != '0)) |
           (id_use_rt_i & (id_rt_i != 5'd0) & (cnt_q[id_rt_i] != '0)));
    sat = id_valid_i & id_reg_write_i & (id_dest_i != 5'd0) &
          (cnt_q[id_dest_i] == CNT_MAX);
  end

  // Pipeline control; everything is forced low while reset is held.
  always_comb begin
    stall_o  = 1'b0;
    issue_o  = 1'b0;
    bubble_o = 1'b0;
    if (rst_ni) begin
      if (state_q == RUN) begin
        stall_o  = raw | sat;
        issue_o  = id_valid_i & ~(raw | sat) & ~flush_i;
        bubble_o = raw | sat | flush_i;
      end else begin
        stall_o  = 1'b1;
        bubble_o = 1'b1;
      end
    end
  end

  // Counter, running total and underflow update; an inc and dec on the same register cancel out.
  always_comb begin
    inc    = issue_o & id_reg_write_i & (id_dest_i != 5'd0);
    dec    = wb_valid_i & (wb_dest_i != 5'd0);
    same   = inc & dec & (id_dest_i == wb_dest_i);
    dec_ok = dec & ~same & (cnt_q[wb_dest_i] != '0);
    err_d  = err_q | (dec & ~same & (cnt_q[wb_dest_i] == '0));
    for (int r = 0; r < NREGS; r++) cnt_d[r] = cnt_q[r];
    if (inc & ~same) cnt_d[id_dest_i] = cnt_q[id_dest_i] + CNT_ONE;
    if (dec_ok)      cnt_d[wb_dest_i] = cnt_q[wb_dest_i] - CNT_ONE;
    inflight_d = inflight_q;
    case ({inc & ~same, dec_ok})
      2'b10:   if (inflight_q != 6'd63) inflight_d = inflight_q + 6'd1;
      2'b01:   if (inflight_q != 6'd0)  inflight_d = inflight_q - 6'd1;
      default: inflight_d = inflight_q;
    endcase
    next_empty = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      if (cnt_d[r] != '0) next_empty = 1'b0;
    end
  end

  // Stall-run watchdog: counts stalled RUN cycles, clears when decode moves, holds at the limit.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == RUN) && stall_o) begin
      if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + SC_ONE;
    end else if (!stall_o) begin
      stall_cnt_d = '0;
    end
    tout_d = tout_q | (stall_cnt_d == STALL_MAX);
  end

  // Drain sequencing: stop issuing, wait for the scoreboard to empty, hold until released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req_i) state_d = next_empty ? IDLE : DRAIN;
      DRAIN:   if (!drain_req_i) state_d = RUN;
               else if (next_empty) state_d = IDLE;
      IDLE:    if (!drain_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State registers; reset discards every pending count at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      tout_q      <= 1'b0;
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      tout_q      <= tout_d;
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Status outputs derived only from registered state.
  always_comb begin
    busy_map_o = '0;
    for (int r = 1; r < NREGS; r++) busy_map_o[r] = (cnt_q[r] != '0);
    inflight_o      = inflight_q;
    drain_done_o    = (state_q == IDLE);
    err_underflow_o = err_q;
    stall_timeout_o = tout_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios with hand-derived expectations,
// followed by a randomized run checked against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_use_rs, id_use_rt, id_reg_write;
  logic        wb_valid, flush, drain_req;
  logic [4:0]  id_rs, id_rt, id_dest, wb_dest;
  logic        stall, issue, bubble, drain_done, err_underflow, stall_timeout;
  logic [31:0] busy_map;
  logic [5:0]  inflight;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: plain pending-write counts per register.
  localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;
  int m_cnt [32];
  int m_infl, m_run, m_mode;
  bit m_err, m_tout;
  bit e_stall, e_issue, e_bubble;
  logic [31:0] e_busy;

  hazard_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_reg_write_i(id_reg_write), .id_dest_i(id_dest),
    .wb_valid_i(wb_valid), .wb_dest_i(wb_dest),
    .flush_i(flush), .drain_req_i(drain_req),
    .stall_o(stall), .issue_o(issue), .bubble_o(bubble),
    .busy_map_o(busy_map), .inflight_o(inflight),
    .drain_done_o(drain_done), .err_underflow_o(err_underflow),
    .stall_timeout_o(stall_timeout)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_reg_write = 0;
    id_rs = 0; id_rt = 0; id_dest = 0;
    wb_valid = 0; wb_dest = 0; flush = 0; drain_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_infl = 0; m_run = 0; m_mode = M_RUN; m_err = 0; m_tout = 0;
  endtask

  function automatic bit m_busy(int r);
    return (r != 0) && (m_cnt[r] != 0);
  endfunction

  function void m_comb();
    bit raw, sat;
    raw = id_valid && ((id_use_rs && m_busy(int'(id_rs))) || (id_use_rt && m_busy(int'(id_rt))));
    sat = id_valid && id_reg_write && (id_dest != 0) && (m_cnt[id_dest] == 3);
    if (m_mode == M_RUN) begin
      e_stall  = raw || sat;
      e_issue  = id_valid && !e_stall && !flush;
      e_bubble = e_stall || flush;
    end else begin
      e_stall = 1; e_issue = 0; e_bubble = 1;
    end
    e_busy = '0;
    for (int r = 1; r < 32; r++) e_busy[r] = (m_cnt[r] != 0);
  endfunction

  task automatic model_step();
    int inc_r, dec_r, total;
    m_comb();
    inc_r = (e_issue && id_reg_write && id_dest != 0) ? int'(id_dest) : 0;
    dec_r = wb_valid ? int'(wb_dest) : 0;
    if (!(inc_r != 0 && inc_r == dec_r)) begin
      if (inc_r != 0) begin
        m_cnt[inc_r]++;
        if (m_infl < 63) m_infl++;
      end
      if (dec_r != 0) begin
        if (m_cnt[dec_r] == 0) m_err = 1;
        else begin
          m_cnt[dec_r]--;
          if (m_infl > 0) m_infl--;
        end
      end
    end
    if (m_mode == M_RUN && e_stall) begin
      if (m_run < 64) m_run++;
      if (m_run == 64) m_tout = 1;
    end else if (!e_stall) m_run = 0;
    total = 0;
    foreach (m_cnt[r]) total += m_cnt[r];
    case (m_mode)
      M_RUN:   if (drain_req) m_mode = (total == 0) ? M_IDLE : M_DRAIN;
      M_DRAIN: if (!drain_req) m_mode = M_RUN; else if (total == 0) m_mode = M_IDLE;
      default: if (!drain_req) m_mode = M_RUN;
    endcase
  endtask

  task automatic test_reset();
    clear_inputs();
    id_valid = 1; flush = 1; id_reg_write = 1; id_dest = 5;
    rst_n = 0;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (issue !== 1'b0) begin failures++; $display("[TB] FAIL reset_issue: got %0b expected 0", issue); end
    checks++; if (bubble !== 1'b0) begin failures++; $display("[TB] FAIL reset_bubble: got %0b expected 0", bubble); end
    checks++; if (busy_map !== 32'h0) begin failures++; $display("[TB] FAIL reset_busy: got %h expected 0", busy_map); end
    checks++; if (inflight !== 6'd0) begin failures++; $display("[TB] FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_drain_done: got %0b expected 0", drain_done); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0b expected 0", err_underflow); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %0b expected 0", stall_timeout); end
    step();
    clear_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 3;
    #1;
    checks++; if (issue !== 1'b1) begin failures++; $display("[TB] FAIL b2b_issue_add: got %0b expected 1", issue); end
    step();
    checks++; if (busy_map !== 32'h8) begin failures++; $display("[TB] FAIL b2b_busy_set: got %h expected 00000008", busy_map); end
    id_reg_write = 0; id_use_rs = 1; id_rs = 3;
    #1;
    checks++; if ({stall, bubble, issue} !== 3'b110) begin failures++; $display("[TB] FAIL b2b_stall: got stall/bubble/issue %b expected 110", {stall, bubble, issue}); end
    wb_valid = 1; wb_dest = 3;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_bypass: got %0b expected 1", stall); end
    step();
    wb_valid = 0;
    #1;
    checks++; if ({stall, issue} !== 2'b01) begin failures++; $display("[TB] FAIL b2b_release: got stall/issue %b expected 01", {stall, issue}); end
    checks++; if (busy_map !== 32'h0) begin failures++; $display("[TB] FAIL b2b_busy_clear: got %h expected 0", busy_map); end
    clear_inputs();
    step();
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 0;
    step();
    checks++; if (busy_map !== 32'h0 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL r0_untracked: got busy %h inflight %0d expected 0 0", busy_map, inflight); end
    id_reg_write = 0; id_use_rs = 1; id_rs = 0; id_use_rt = 1; id_rt = 0;
    wb_valid = 1; wb_dest = 0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL r0_no_stall: got %0b expected 0", stall); end
    step();
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL r0_wb_ignored: got %0b expected 0", err_underflow); end
    clear_inputs();
    step();
  endtask

  task automatic test_same_cycle_and_sat();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 5;
    step();
    wb_valid = 1; wb_dest = 5;
    step();
    checks++; if (busy_map !== 32'h20 || inflight !== 6'd1) begin failures++; $display("[TB] FAIL incdec_r5: got busy %h inflight %0d expected 00000020 1", busy_map, inflight); end
    id_valid = 0;
    step();
    checks++; if (busy_map !== 32'h0 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL r5_retired: got busy %h inflight %0d expected 0 0", busy_map, inflight); end
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 7;
    repeat (3) step();
    #1;
    checks++; if ({stall, issue, bubble} !== 3'b101) begin failures++; $display("[TB] FAIL sat_r7: got stall/issue/bubble %b expected 101", {stall, issue, bubble}); end
    checks++; if (inflight !== 6'd3) begin failures++; $display("[TB] FAIL sat_inflight: got %0d expected 3", inflight); end
    clear_inputs();
    wb_valid = 1; wb_dest = 7;
    repeat (3) step();
    wb_valid = 0;
    checks++; if (busy_map !== 32'h0 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL sat_drained: got busy %h inflight %0d expected 0 0", busy_map, inflight); end
    step();
  endtask

  task automatic test_flush();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 4; flush = 1;
    #1;
    checks++; if ({stall, issue, bubble} !== 3'b001) begin failures++; $display("[TB] FAIL flush_ctrl: got stall/issue/bubble %b expected 001", {stall, issue, bubble}); end
    step();
    checks++; if (busy_map !== 32'h0 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL flush_counters: got busy %h inflight %0d expected 0 0", busy_map, inflight); end
    clear_inputs();
    step();
  endtask

  task automatic test_drain();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_dest = 1;
    step();
    id_dest = 2;
    step();
    id_valid = 0; id_reg_write = 0; drain_req = 1;
    step();
    id_valid = 1; id_dest = 6;
    #1;
    checks++; if ({stall, issue, bubble, drain_done} !== 4'b1010) begin failures++; $display("[TB] FAIL drain_block: got stall/issue/bubble/done %b expected 1010", {stall, issue, bubble, drain_done}); end
    wb_valid = 1; wb_dest = 1;
    step();
    checks++; if (drain_done !== 1'b0) begin failures++; $display("[TB] FAIL drain_early: got %0b expected 0", drain_done); end
    wb_dest = 2;
    step();
    wb_valid = 0;
    checks++; if (drain_done !== 1'b1 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL drain_done: got done %0b inflight %0d expected 1 0", drain_done, inflight); end
    drain_req = 0;
    #1;
    checks++; if (issue !== 1'b0) begin failures++; $display("[TB] FAIL idle_hold: got %0b expected 0", issue); end
    step();
    checks++; if (issue !== 1'b1 || drain_done !== 1'b0) begin failures++; $display("[TB] FAIL drain_resume: got issue %0b done %0b expected 1 0", issue, drain_done); end
    clear_inputs();
    drain_req = 1;
    step();
    checks++; if (drain_done !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty: got %0b expected 1", drain_done); end
    drain_req = 0;
    step();
    step();
  endtask

  task automatic test_errors();
    clear_inputs();
    wb_valid = 1; wb_dest = 9;
    step();
    wb_valid = 0;
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("[TB] FAIL underflow_set: got %0b expected 1", err_underflow); end
    repeat (2) step();
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("[TB] FAIL underflow_sticky: got %0b expected 1", err_underflow); end
    id_valid = 1; id_reg_write = 1; id_dest = 10;
    step();
    id_reg_write = 0; id_use_rs = 1; id_rs = 10;
    repeat (63) step();
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %0b expected 0", stall_timeout); end
    step();
    checks++; if (stall_timeout !== 1'b1) begin failures++; $display("[TB] FAIL timeout_set: got %0b expected 1", stall_timeout); end
    #2;
    rst_n = 0;
    #1;
    checks++; if ({stall, issue, bubble, drain_done, err_underflow, stall_timeout} !== 6'b0) begin failures++; $display("[TB] FAIL midreset_ctrl: got %b expected 000000", {stall, issue, bubble, drain_done, err_underflow, stall_timeout}); end
    checks++; if (busy_map !== 32'h0 || inflight !== 6'd0) begin failures++; $display("[TB] FAIL midreset_counts: got busy %h inflight %0d expected 0 0", busy_map, inflight); end
    #1;
    rst_n = 1;
    clear_inputs();
    wb_valid = 1; wb_dest = 10;
    step();
    wb_valid = 0;
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("[TB] FAIL stale_wb: got %0b expected 1", err_underflow); end
    step();
  endtask

  task automatic test_random();
    int busy_list[$];
    clear_inputs();
    rst_n = 0;
    #1;
    model_reset();
    rst_n = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid     = ($urandom_range(9) < 8);
      id_use_rs    = 1'($urandom_range(1));
      id_use_rt    = 1'($urandom_range(1));
      id_reg_write = 1'($urandom_range(1));
      id_rs        = 5'($urandom_range(7));
      id_rt        = 5'($urandom_range(7));
      id_dest      = 5'($urandom_range(7));
      flush        = ($urandom_range(9) == 0);
      if ($urandom_range(15) == 0) drain_req = ~drain_req;
      busy_list = {};
      for (int r = 1; r < 8; r++) if (m_cnt[r] != 0) busy_list.push_back(r);
      wb_valid = 1'($urandom_range(1));
      if (busy_list.size() != 0 && $urandom_range(4) != 0)
        wb_dest = 5'(busy_list[$urandom_range(busy_list.size() - 1)]);
      else
        wb_dest = 5'($urandom_range(7));
      #1;
      m_comb();
      checks++; if (stall !== e_stall) begin failures++; $display("[TB] FAIL rnd_stall cyc %0d: got %0b expected %0b", cyc, stall, e_stall); end
      checks++; if (issue !== e_issue) begin failures++; $display("[TB] FAIL rnd_issue cyc %0d: got %0b expected %0b", cyc, issue, e_issue); end
      checks++; if (bubble !== e_bubble) begin failures++; $display("[TB] FAIL rnd_bubble cyc %0d: got %0b expected %0b", cyc, bubble, e_bubble); end
      checks++; if (busy_map !== e_busy) begin failures++; $display("[TB] FAIL rnd_busy cyc %0d: got %h expected %h", cyc, busy_map, e_busy); end
      checks++; if (inflight !== 6'(m_infl)) begin failures++; $display("[TB] FAIL rnd_inflight cyc %0d: got %0d expected %0d", cyc, inflight, m_infl); end
      checks++; if (drain_done !== (m_mode == M_IDLE)) begin failures++; $display("[TB] FAIL rnd_drain_done cyc %0d: got %0b expected %0b", cyc, drain_done, m_mode == M_IDLE); end
      checks++; if (err_underflow !== m_err) begin failures++; $display("[TB] FAIL rnd_err cyc %0d: got %0b expected %0b", cyc, err_underflow, m_err); end
      checks++; if (stall_timeout !== m_tout) begin failures++; $display("[TB] FAIL rnd_timeout cyc %0d: got %0b expected %0b", cyc, stall_timeout, m_tout); end
      model_step();
      step();
    end
    clear_inputs();
    step();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_reg_zero();
    test_same_cycle_and_sat();
    test_flush();
    test_drain();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage hazard controller for the MUSA core. It tracks, per architectural register, how many issued instructions still owe a write-back. It stalls the fetch/decode pair, and bubbles the decode-to-execute register, while a decoding instruction reads a register with a pending write. It also provides a drain handshake so the core can be quiesced before interrupts, debug or stack-pointer swaps. It sits beside the decode stage: it consumes decoded register fields and the write-back port's register/valid, and drives PC-write, IF/ID-write and bubble-insert enables.

## Interface
- NREGS, 32, architectural registers; address width fixed at 5; register 0 never tracked
- CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 in flight per register)
- STALL_LIMIT, 64, consecutive stall cycles before stall_timeout asserts
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a valid instruction
- id_rs / id_rt  in  5 each  source register fields (instruction[25:21], [20:16])
- id_use_rs / id_use_rt  in  1 each  instruction actually reads that source
- id_reg_write  in  1  instruction will write a register
- id_dest  in  5  destination after RegDst selection
- wb_valid  in  1  write-back port commits this cycle
- wb_dest  in  5  register being committed
- flush  in  1  squash the decoding instruction (taken jump/branch); no issue this cycle
- drain_req  in  1  level request to stop issuing and empty the pipe
- stall  out  1  hold PC and IF/ID (pc_write = if_id_write = ~stall)
- issue  out  1  decoding instruction advances this cycle
- bubble  out  1  load NOP into ID/EX this cycle
- busy_map  out  32  bit r = (cnt[r] != 0); bit 0 always 0
- inflight  out  6  total pending writes across all registers, saturating at 63
- drain_done  out  1  drained and idle
- err_underflow  out  1  sticky: write-back to a register with cnt 0
- stall_timeout  out  1  sticky: stall run reached STALL_LIMIT

## Operation
- Hazard terms: raw = id_valid & ((id_use_rs & id_rs != 0 & cnt[id_rs] != 0) | (id_use_rt & id_rt != 0 & cnt[id_rt] != 0)); sat = id_valid & id_reg_write & id_dest != 0 & cnt[id_dest] == max.
- No same-cycle bypass. A write-back in cycle N clears busy only from cycle N+1.
- FSM states:
  - RUN, reset state: stall = raw | sat; issue = id_valid & ~stall & ~flush; bubble = stall | flush.
  - DRAIN, entered from RUN when drain_req = 1: issue = 0, stall = 1, bubble = 1. Go to IDLE when all counters are 0. Return to RUN if drain_req drops first.
  - IDLE: stall = 1, bubble = 1, drain_done = 1. Return to RUN when drain_req = 0.
- Counter update on each edge (reg 0 ignored):
  - inc = issue & id_reg_write; dec = wb_valid.
  - inc only on id_dest: +1. dec only on wb_dest: -1.
  - inc and dec on the same register: unchanged.
  - dec when cnt = 0: counter stays 0 and err_underflow is set.
- inflight is the registered total. It is adjusted by the same inc/dec rule and saturates at 0 and 63.
- Stall counter: increments on each RUN cycle with stall = 1 and clears on any cycle without stall. When it reaches STALL_LIMIT, stall_timeout is set, and the counter holds at that value.
- flush has priority over issue. It does not affect counters of already-issued instructions, which still write back.

## Timing
- Reset values (asynchronous, rst = 0):
  - All counters, inflight, stall counter, err_underflow and stall_timeout are 0.
  - State is RUN.
  - stall = 0, issue = 0, bubble = 0, drain_done = 0, busy_map = 0.
- stall, issue and bubble are combinational from current inputs plus registered state. Zero-cycle latency.
- busy_map, inflight, drain_done, err_underflow and stall_timeout are registered or derived from registered state only.
- Issue at edge N → busy visible in cycle N+1. Write-back at edge N → busy clears in cycle N+1.
- drain_req rising in cycle N: issue is blocked from cycle N+1. drain_done asserts the cycle after the last counter reaches 0, or in cycle N+1 if already empty.
- Reset asserted mid-operation discards all pending counts immediately. The bench must not expect write-backs issued before reset to decrement anything (they raise err_underflow).

## Test plan
- Back-to-back dependency: issue add r3 (reg_write, dest 3), next cycle decode reads rs = 3 → stall = 1, bubble = 1. wb_valid with wb_dest = 3 → stall = 0 the following cycle; busy_map[3] goes 1 → 0.
- Register 0: dest 0 issued, then rs = 0 read → never stalls; busy_map = 0, inflight unchanged.
- Simultaneous inc/dec on r5 (cnt 1, issue dest 5 with wb_dest 5) → cnt stays 1 and inflight unchanged. Three issues to r7 without write-back → the fourth stalls on sat with CNT_W = 2.
- Flush: id_valid = 1, no hazard, flush = 1 → issue = 0, bubble = 1, counters unchanged.
- Drain: 2 writes in flight, assert drain_req → issue = 0. Two write-backs → drain_done = 1 one cycle after the second. Drop drain_req → RUN; issue resumes.
- Errors: wb_dest = 9 with cnt 0 → err_underflow = 1, sticky. Hold a hazard 64 cycles → stall_timeout = 1. Async rst mid-stall → all outputs 0 before the next clk edge.
